odo_nonce_feeder: RTL and testbench

Work-unit sequencer directly upstream of the Odo encryption pipeline. Holds one 640-bit (80-byte) block-header template, substitutes a stepping 32-bit nonce into it, and emits one complete header per cycle on an `out`/`write` pair that connects straight to the encryptor's `in`/`read`. The encryptor has no backpressure, so this block is the only point of flow control. It runs a programmable nonce range and reports completion.

---
 rtl/odo_nonce_feeder.sv | 107 ++++++++++
 tb/tb_odo_nonce_feeder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/odo_nonce_feeder.sv
// odo_nonce_feeder: steps a 32-bit nonce through a loaded header template
// and feeds one complete header per cycle to the Odo encryptor.
module odo_nonce_feeder #(
    parameter int unsigned STRIDE    = 1,
    parameter int unsigned NONCE_LSB = 608
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [639:0] hdr_in,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic         run,
    input  logic         stop,
    output logic [639:0] out,
    output logic         write,
    output logic [31:0]  nonce,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Stride widened to 33 bits so the end-of-range compare never wraps.
    localparam logic [32:0] STEP = 33'(STRIDE);

    state_e       state_q, state_d;
    logic [639:0] hdr_q, hdr_d;
    logic [31:0]  cur_q, cur_d;
    logic [31:0]  last_q, last_d;
    logic [639:0] out_q, out_d;
    logic         write_q, write_d;
    logic [31:0]  nonce_q, nonce_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [32:0]  nxt;

    // Next-state: load beats stop, stop beats emission.
    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        cur_d   = cur_q;
        last_d  = last_q;
        out_d   = out_q;
        nonce_d = nonce_q;
        write_d = 1'b0;
        nxt     = {1'b0, cur_q} + STEP;

        if (load) begin
            hdr_d   = hdr_in;
            cur_d   = nonce_start;
            last_d  = nonce_end;
            state_d = (nonce_start <= nonce_end) ? S_RUN : S_DONE;
        end else if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else if (state_q == S_RUN && run) begin
            out_d                     = hdr_q;
            out_d[NONCE_LSB +: 32]    = cur_q;
            nonce_d                   = cur_q;
            write_d                   = 1'b1;
            if (nxt > {1'b0, last_q}) begin
                state_d = S_DONE;
            end else begin
                cur_d = nxt[31:0];
            end
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs; everything clears on async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hdr_q   <= '0;
            cur_q   <= '0;
            last_q  <= '0;
            out_q   <= '0;
            write_q <= 1'b0;
            nonce_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            out_q   <= out_d;
            write_q <= write_d;
            nonce_q <= nonce_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out   = out_q;
    assign write = write_q;
    assign nonce = nonce_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_odo_nonce_feeder.sv
// tb_odo_nonce_feeder: directed checks of range stepping, stride, pause,
// reload, stop and async reset against hand-computed nonce sequences.
module tb_odo_nonce_feeder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic [639:0] hdr_in;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_end = '0;
    logic         run = 1'b0;
    logic         stop = 1'b0;

    logic [639:0] out1, out3;
    logic         wr1, wr3;
    logic [31:0]  nc1, nc3;
    logic         busy1, busy3;
    logic         done1, done3;

    int n_chk = 0;
    int n_err = 0;

    logic [639:0] tmpl;
    logic [639:0] exp_out;

    always #5 clk = ~clk;

    odo_nonce_feeder #(.STRIDE(1), .NONCE_LSB(608)) u1 (
        .clk(clk), .rst_n(rst_n), .load(load), .hdr_in(hdr_in),
        .nonce_start(nonce_start), .nonce_end(nonce_end),
        .run(run), .stop(stop), .out(out1), .write(wr1),
        .nonce(nc1), .busy(busy1), .done(done1)
    );

    odo_nonce_feeder #(.STRIDE(3), .NONCE_LSB(608)) u3 (
        .clk(clk), .rst_n(rst_n), .load(load), .hdr_in(hdr_in),
        .nonce_start(nonce_start), .nonce_end(nonce_end),
        .run(run), .stop(stop), .out(out3), .write(wr3),
        .nonce(nc3), .busy(busy3), .done(done3)
    );

    task automatic check(input string tag, input logic [639:0] got,
                         input logic [639:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Pulse load for one edge; sampling resumes at the following negedge.
    task automatic do_load(input logic [31:0] s, input logic [31:0] e);
        load        = 1'b1;
        nonce_start = s;
        nonce_end   = e;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Expect n consecutive headers s, s+stride, ... with done on the last.
    task automatic run_seq(input bit sel3, input logic [31:0] s,
                           input int n, input logic [31:0] stride,
                           input string tag);
        logic [31:0] en;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            en = s + 32'(k) * stride;
            check({tag, "_wr"}, 640'(sel3 ? wr3 : wr1), 640'(1));
            check({tag, "_nonce"}, 640'(sel3 ? nc3 : nc1), 640'(en));
            check({tag, "_busy"}, 640'(sel3 ? busy3 : busy1),
                  640'(k != n - 1));
            check({tag, "_done"}, 640'(sel3 ? done3 : done1),
                  640'(k == n - 1));
            if (k == 0) begin
                exp_out = tmpl;
                exp_out[639:608] = en;
                check({tag, "_out"}, sel3 ? out3 : out1, exp_out);
            end
        end
        @(negedge clk);
        check({tag, "_wr_end"}, 640'(sel3 ? wr3 : wr1), 640'(0));
        check({tag, "_done_end"}, 640'(sel3 ? done3 : done1), 640'(1));
    endtask

    initial begin
        for (int i = 0; i < 80; i++) tmpl[i*8 +: 8] = 8'(i * 7 + 3);
        hdr_in = tmpl;

        #2;
        check("rst_out", out1, 640'(0));
        check("rst_wr", 640'(wr1), 640'(0));
        check("rst_nonce", 640'(nc1), 640'(0));
        check("rst_busy", 640'(busy1), 640'(0));
        check("rst_done", 640'(done1), 640'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;

        // Basic range, stride 1.
        do_load(32'h10, 32'h13);
        check("b_busy0", 640'(busy1), 640'(1));
        check("b_wr0", 640'(wr1), 640'(0));
        check("b_done0", 640'(done1), 640'(0));
        run_seq(1'b0, 32'h10, 4, 32'd1, "basic");

        // Stride 3, end on and off the grid.
        do_load(32'd5, 32'd14);
        run_seq(1'b1, 32'd5, 4, 32'd3, "s3a");
        do_load(32'd5, 32'd13);
        run_seq(1'b1, 32'd5, 3, 32'd3, "s3b");

        // Empty range goes straight to done.
        do_load(32'd9, 32'd8);
        check("empty_done", 640'(done1), 640'(1));
        check("empty_busy", 640'(busy1), 640'(0));
        check("empty_wr", 640'(wr1), 640'(0));
        @(negedge clk);
        check("empty_wr2", 640'(wr1), 640'(0));

        // Top of nonce space: no wrap past 0xFFFFFFFF.
        do_load(32'hFFFF_FFFE, 32'hFFFF_FFFF);
        run_seq(1'b0, 32'hFFFF_FFFE, 2, 32'd1, "top");
        do_load(32'hFFFF_FFFE, 32'hFFFF_FFFF);
        run_seq(1'b1, 32'hFFFF_FFFE, 1, 32'd3, "top3");

        // Pause after the 2nd header of a 6-nonce range.
        do_load(32'h100, 32'h105);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("p_pre", 640'(nc1), 640'(32'h100 + k));
        end
        run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("p_gap_wr", 640'(wr1), 640'(0));
            check("p_gap_busy", 640'(busy1), 640'(1));
            check("p_gap_nonce", 640'(nc1), 640'(32'h101));
        end
        run = 1'b1;
        run_seq(1'b0, 32'h102, 4, 32'd1, "p_post");

        // Reload while running.
        do_load(32'h200, 32'h20F);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rl_old", 640'(nc1), 640'(32'h200 + k));
        end
        do_load(32'h300, 32'h302);
        check("rl_wr", 640'(wr1), 640'(0));
        check("rl_busy", 640'(busy1), 640'(1));
        run_seq(1'b0, 32'h300, 3, 32'd1, "rl_new");

        // stop and load on the same edge: load wins.
        do_load(32'h400, 32'h40F);
        @(negedge clk);
        check("sl_old", 640'(nc1), 640'(32'h400));
        stop = 1'b1;
        do_load(32'h500, 32'h501);
        stop = 1'b0;
        check("sl_busy", 640'(busy1), 640'(1));
        check("sl_wr", 640'(wr1), 640'(0));
        @(negedge clk);
        check("sl_nonce", 640'(nc1), 640'(32'h500));

        // stop alone.
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("st_busy", 640'(busy1), 640'(0));
        check("st_done", 640'(done1), 640'(0));
        check("st_wr", 640'(wr1), 640'(0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("st_idle_wr", 640'(wr1), 640'(0));
        end

        // Async reset in the middle of a range.
        do_load(32'h600, 32'h6FF);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("ar_pre", 640'(nc1), 640'(32'h600 + k));
        end
        #2 rst_n = 1'b0;
        #1;
        check("ar_wr", 640'(wr1), 640'(0));
        check("ar_busy", 640'(busy1), 640'(0));
        check("ar_done", 640'(done1), 640'(0));
        check("ar_nonce", 640'(nc1), 640'(0));
        check("ar_out", out1, 640'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("ar_post_wr", 640'(wr1), 640'(0));
            check("ar_post_busy", 640'(busy1), 640'(0));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
